ram8_port_arbiter: RTL and testbench

Two-requester arbiter for port A of the 2K x 8 dual-port block RAM. It lets the CPU datapath and the loader/DMA engine share that single synchronous port, one access per cycle. It registers the winning command onto the RAM port and returns read data to the owning requester with fixed latency. Port B of the RAM is not touched by this block.

---
 rtl/ram8_port_arbiter_pkg.sv | 27 ++
 rtl/ram8_port_arbiter_rr2_pick.sv | 32 +++
 rtl/ram8_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram8_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port-A arbiter.
// Requester IDs are one bit wide; the tag follows a command down the pipe.
package ram8_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ID_W       = 1;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
    logic we;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0, we: 1'b0};

  function automatic tag_t mk_tag(input logic id, input logic we);
    tag_t t;
    t.valid = 1'b1;
    t.id    = id_t'(id);
    t.we    = we;
    return t;
  endfunction

endpackage

// File: rtl/ram8_port_arbiter_rr2_pick.sv
// Two-way round-robin pick with optional retention by the last winner.
// A held lock wins contention until the hold budget is spent.
module rr2_pick
  import ram8_port_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_gnt_i,
  input  logic       lock_i,
  input  logic       hold_exp_i,
  output logic       win_o,
  output logic [1:0] gnt_o
);

  logic both;
  logic keep;

  assign both = valid_i[0] & valid_i[1];
  assign keep = lock_i & ~hold_exp_i;

  always_comb begin
    win_o = 1'b0;
    unique case (1'b1)
      both && keep:         win_o = last_gnt_i;
      both && !keep:        win_o = ~last_gnt_i;
      valid_i == 2'b10:     win_o = 1'b1;
      default:              win_o = 1'b0;
    endcase
  end

  assign gnt_o = valid_i & (win_o ? 2'b10 : 2'b01);

endmodule

// File: rtl/ram8_port_arbiter.sv
// Shares RAM port A between two requesters, one access per cycle.
// Define RAM_ARB_LOCK_EN to honour reqN_lock with a MAX_HOLD cap.
module ram8_port_arbiter
  import ram8_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0]        valid;
  logic [1:0]        gnt;
  logic              win;
  logic              xfer;
  logic              lock_keep;
  logic              hold_exp;

  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  tag_t              s1_q, s1_d;
  tag_t              s2_q, s2_d;
  logic              rsp_rd;

  assign valid = {req1_valid, req0_valid};

`ifdef RAM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic [1:0]       lock_in;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign lock_in   = {req1_lock, req0_lock};
  assign lock_keep = lock_q & valid[last_gnt_q] & lock_in[last_gnt_q];
  assign hold_exp  = (cnt_q >= CNT_W'(MAX_HOLD));

  // Count consecutive locked grants to the same requester; saturate.
  always_comb begin
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      if (lock_in[win]) begin
        lock_d = 1'b1;
        if (win == last_gnt_q && lock_q) begin
          cnt_d = hold_exp ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(1);
        end
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (!lock_keep) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = req0_lock ^ req1_lock;
  assign lock_keep   = 1'b0;
  assign hold_exp    = 1'b0;
`endif

  rr2_pick u_pick (
    .valid_i    (valid),
    .last_gnt_i (last_gnt_q),
    .lock_i     (lock_keep),
    .hold_exp_i (hold_exp),
    .win_o      (win),
    .gnt_o      (gnt)
  );

  assign req0_ready = gnt[0] & ~rst;
  assign req1_ready = gnt[1] & ~rst;
  assign xfer       = req0_ready | req1_ready;

  always_comb begin
    last_gnt_d  = last_gnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    s1_d        = TAG_IDLE;
    s2_d        = s1_q;
    if (xfer) begin
      last_gnt_d  = win;
      ram_addr_d  = win ? req1_addr : req0_addr;
      ram_wdata_d = win ? req1_wdata : req0_wdata;
      ram_we_d    = win ? req1_we : req0_we;
      s1_d        = mk_tag(win, ram_we_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      s1_q        <= TAG_IDLE;
      s2_q        <= TAG_IDLE;
    end else begin
      last_gnt_q  <= last_gnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;

  // RAM data lands two cycles after acceptance, aligned with S2.
  assign rsp_rd     = s2_q.valid & ~s2_q.we;
  assign rsp0_valid = rsp_rd & (s2_q.id == id_t'(0));
  assign rsp1_valid = rsp_rd & (s2_q.id == id_t'(1));
  assign rsp0_rdata = ram_q;
  assign rsp1_rdata = ram_q;

endmodule

// File: tb/tb_ram8_port_arbiter.sv
// Directed bench for ram8_port_arbiter with a behavioural 2K x 8 RAM.
module tb_ram8_port_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_we, req0_lock, req0_ready;
  logic [10:0] req0_addr;
  logic [7:0]  req0_wdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready;
  logic [10:0] req1_addr;
  logic [7:0]  req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_rdata, rsp1_rdata;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic [7:0]  mem [0:2047];

  int errors = 0;
  int checks = 0;

  ram8_port_arbiter #(.ADDR_W(11), .DATA_W(8), .MAX_HOLD(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[0]     = 8'h11;
    mem[1]     = 8'h22;
    mem[11'h010] = 8'h42;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [10:0] a,
                      input logic [7:0] d, input logic l);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_lock = l;
  endtask

  task automatic set1(input logic v, input logic we, input logic [10:0] a,
                      input logic [7:0] d, input logic l);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_lock = l;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (n) tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set0(1, 1, 11'h123, 8'h55, 0);
    set1(1, 0, 11'h321, 8'h66, 0);
    tick();
    tick();
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got=%b want=00", {req1_ready, req0_ready});
    end
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 11'h000 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_ram got we=%b a=%h d=%h want 0/000/00", ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_rsp got=%b want=00", {rsp1_valid, rsp0_valid});
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    set0(1, 0, 11'h010, 8'h00, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL single_ready got=%b want=01", {req1_ready, req0_ready});
    end
    tick();
    set0(0, 0, 0, 0, 0);
    checks++;
    if (ram_addr !== 11'h010 || ram_we !== 1'b0) begin
      errors++; $display("FAIL single_cmd got a=%h we=%b want 010/0", ram_addr, ram_we);
    end
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got=%b want=0", rsp0_valid);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'h42 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got v0=%b d=%h v1=%b want 1/42/0", rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse got=%b want=0", rsp0_valid);
    end
  endtask

  task automatic test_contention;
    logic [7:0] want_d;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        set0(1, 0, 11'h000, 8'h00, 0);
        set1(1, 0, 11'h001, 8'h00, 0);
      end else begin
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
      end
      #1;
      if (i < 6) begin
        checks++;
        if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL cont_gnt[%0d] got=%b%b want=%b%b", i, req1_ready, req0_ready,
                   (i % 2 == 1), (i % 2 == 0));
        end
      end
      if (i >= 2) begin
        want_d = ((i - 2) % 2 == 0) ? 8'h11 : 8'h22;
        checks++;
        if (rsp0_valid !== ((i - 2) % 2 == 0) || rsp1_valid !== ((i - 2) % 2 == 1)) begin
          errors++;
          $display("FAIL cont_rspv[%0d] got=%b%b", i, rsp1_valid, rsp0_valid);
        end
        checks++;
        if (rsp0_valid === 1'b1 ? rsp0_rdata !== want_d : rsp1_rdata !== want_d) begin
          errors++;
          $display("FAIL cont_data[%0d] got=%h/%h want=%h", i, rsp0_rdata, rsp1_rdata, want_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_read;
    set1(1, 1, 11'h7FF, 8'hA5, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("FAIL wr_ready got=%b want=10", {req1_ready, req0_ready});
    end
    tick();
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 11'h7FF, 8'h00, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rd_ready got=%b want=1", req0_ready);
    end
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 11'h7FF || ram_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_cmd got we=%b a=%h d=%h want 1/7ff/a5", ram_we, ram_addr, ram_wdata);
    end
    tick();
    set0(0, 0, 0, 0, 0);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++; $display("FAIL wr_norsp got=%b want=00", {rsp1_valid, rsp0_valid});
    end
    tick();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_rdata !== 8'hA5 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_rsp got v0=%b d=%h v1=%b want 1/a5/0", rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    tick();
  endtask

  task automatic test_reset_midflight;
    set0(1, 0, 11'h010, 8'h00, 0);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL mid_accept got=%b want=1", req0_ready);
    end
    tick();
    rst = 1'b1;
    set0(1, 1, 11'h020, 8'h77, 0);
    set1(1, 1, 11'h021, 8'h88, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_ready got=%b want=00", {req1_ready, req0_ready});
    end
    tick();
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++; $display("FAIL mid_drop got=%b want=00", {rsp1_valid, rsp0_valid});
    end
    checks++;
    if (ram_we !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_inreset got we=%b rdy=%b want 0/00", ram_we, {req1_ready, req0_ready});
    end
    rst = 1'b0;
    set0(1, 0, 11'h000, 8'h00, 0);
    set1(1, 0, 11'h001, 8'h00, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL mid_first got=%b want=01", {req1_ready, req0_ready});
    end
    tick();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    checks++;
    if (mem[11'h020] !== 8'h00 || mem[11'h021] !== 8'h00) begin
      errors++;
      $display("FAIL mid_nowrite got=%h/%h want=00/00", mem[11'h020], mem[11'h021]);
    end
    tick();
    tick();
  endtask

  task automatic test_lock;
    logic [7:0] exp_g;
`ifdef RAM_ARB_LOCK_EN
    exp_g = 8'b1000_1000;
`else
    exp_g = 8'b1010_1010;
`endif
    do_reset(2);
    set0(1, 0, 11'h000, 8'h00, 1);
    set1(1, 0, 11'h001, 8'h00, 0);
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (req1_ready !== exp_g[i] || req0_ready !== !exp_g[i]) begin
        errors++;
        $display("FAIL lock_gnt[%0d] got=%b%b want=%b%b", i, req1_ready, req0_ready,
                 exp_g[i], !exp_g[i]);
      end
      tick();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_reset_midflight();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
